// File: rtl/pu_mac_sequencer_if.sv
// Host-bus and PU-side signal bundle for pu_mac_sequencer.
// The sequencer uses the slave modport; the host/PU side uses master.
interface pu_mac_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic                  wr_en;
  logic                  wr_sel;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  start;
  logic [LW-1:0]         len;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_WIDTH-1:0] result;
  logic                  pu_clr;
  logic                  pu_en;
  logic [DATA_WIDTH-1:0] pu_a;
  logic [DATA_WIDTH-1:0] pu_b;
  logic [DATA_WIDTH-1:0] pu_p;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, len, pu_p,
    input  busy, done, err, result, pu_clr, pu_en, pu_a, pu_b
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, len, pu_p,
    output busy, done, err, result, pu_clr, pu_en, pu_a, pu_b
  );
endinterface

// File: rtl/pu_mac_sequencer.sv
// Drives one MAC PU through clear/stream/drain; done arrives len+PU_LATENCY+2 cycles after start.
// No backpressure: start and writes are honoured only in IDLE, otherwise dropped (never queued).
module pu_mac_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int PU_LATENCY = 1
) (
  input logic               clk,
  input logic               reset,
  pu_mac_sequencer_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (PU_LATENCY > 1) ? $clog2(PU_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [LW-1:0]         r_len;
  logic [AW-1:0]         r_idx;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_buf_a [DEPTH];
  logic [DATA_WIDTH-1:0] r_buf_b [DEPTH];

  logic w_len_ok;
  logic w_last_run;
  logic w_drain_end;
  logic w_idle;

  assign w_idle      = (r_state == S_IDLE);
  assign w_len_ok    = (bus.len != '0) && (bus.len <= LW'(DEPTH));
  assign w_last_run  = (LW'(r_idx) == (r_len - LW'(1)));
  assign w_drain_end = (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start && w_len_ok) w_next = S_CLEAR;
      S_CLEAR: w_next = S_RUN;
      S_RUN:   if (w_last_run) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Buffers are writable only while idle, so a running job always sees a stable snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_a[i] <= '0;
        r_buf_b[i] <= '0;
      end
    end else if (w_idle && bus.wr_en) begin
      if (bus.wr_sel) r_buf_b[bus.wr_addr] <= bus.wr_data;
      else            r_buf_a[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_idle && bus.start && !w_len_ok;
      case (r_state)
        S_IDLE: begin
          if (bus.start && w_len_ok) begin
            r_len <= bus.len;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          // Hold idx on the final pair so len=DEPTH never wraps the index.
          if (w_last_run) r_cnt <= CW'(PU_LATENCY - 1);
          else            r_idx <= r_idx + AW'(1);
        end
        S_DRAIN: begin
          if (w_drain_end) r_result <= bus.pu_p;
          else             r_cnt    <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = !w_idle;
  assign bus.done   = (r_state == S_DONE);
  assign bus.err    = r_err;
  assign bus.result = r_result;
  assign bus.pu_clr = (r_state == S_CLEAR);
  assign bus.pu_en  = (r_state == S_RUN);
  assign bus.pu_a   = (r_state == S_RUN) ? r_buf_a[r_idx] : '0;
  assign bus.pu_b   = (r_state == S_RUN) ? r_buf_b[r_idx] : '0;
endmodule

// File: doc/pu_mac_sequencer.md
# pu_mac_sequencer

Sequencer for a single PU multiply-accumulate processing unit. It holds two operand vectors in local buffers written by the host. On `start` it clears the PU, streams `len` operand pairs into it (one per cycle) and waits out the PU latency. It then captures the accumulated dot product and signals completion with a one-cycle `done` pulse. It sits between the host/control bus and one PU instance, and it is the only driver of the PU's `en`/`a`/`b` and clear inputs.

## Interface
- `DATA_WIDTH`, 16: operand and result width; must match the PU instance.
- `DEPTH`, 16: operand buffer entries, which is the maximum vector length.
- `PU_LATENCY`, 1: cycles from the last `pu_en` edge until `pu_p` holds the final sum; must be at least 1.
- `LW` (local): `$clog2(DEPTH+1)`. `AW` (local): `$clog2(DEPTH)`.

- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low reset (block is in reset while `reset`=0).
- `wr_en` in 1: write strobe for the operand buffers.
- `wr_sel` in 1: 0 writes buffer A, 1 writes buffer B.
- `wr_addr` in AW: buffer index.
- `wr_data` in DATA_WIDTH: operand value.
- `start` in 1: job request, sampled only in IDLE.
- `len` in LW: vector length, sampled together with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse, high while `result` is newly valid.
- `err` out 1: one-cycle pulse on a rejected `start`.
- `result` out DATA_WIDTH: last captured sum; holds its value until the next capture.
- `pu_clr` out 1: active-high clear to the PU `reset`.
- `pu_en` out 1: PU accumulate enable.
- `pu_a`, `pu_b` out DATA_WIDTH: PU operands.
- `pu_p` in DATA_WIDTH: PU accumulator output.

## Operation
- **Reset values:** all outputs are 0, the FSM is in IDLE, `idx`/`cnt` are 0 and both buffers are zero-filled.
- **PU contract:** on a clock edge, `pu_clr`=1 gives P←0; otherwise `pu_en`=1 gives P←P+a·b, truncated to DATA_WIDTH.
- **States:** IDLE → CLEAR → RUN → DRAIN → DONE → IDLE.
- **IDLE:**
  - `start`=1 with 1≤`len`≤DEPTH: latch `len`, set `idx`=0, go to CLEAR.
  - `start`=1 with `len`=0 or `len`>DEPTH: pulse `err` for 1 cycle and stay in IDLE; `busy` stays 0.
- **CLEAR (1 cycle):** `pu_clr`=1, `pu_en`=0, then go to RUN.
- **RUN (`len` cycles):**
  - `pu_en`=1, `pu_a`=A[idx], `pu_b`=B[idx], where idx is a register and the buffer read is combinational.
  - `idx` increments every cycle; when idx=len−1, go to DRAIN with `cnt`=PU_LATENCY−1.
- **DRAIN (PU_LATENCY cycles):** `pu_en`=0. On the last DRAIN edge, `result`←`pu_p` and go to DONE.
- **DONE (1 cycle):** `done`=1, then go to IDLE.
- **Idle drive:** outside RUN, `pu_a`/`pu_b` are driven to 0.
- **Writes:**
  - `wr_en` is accepted only in IDLE; writes while `busy`=1 are dropped.
  - A write and a `start` in the same IDLE cycle: the write lands first, so the job sees the new value.
- `start` while busy is ignored and is not queued.
- **Arithmetic:** `result` is the dot product of A[0..len−1] and B[0..len−1] modulo 2^DATA_WIDTH. No saturation and no overflow flag.

## Timing
- Edge 0 samples `start`. CLEAR is cycle 1, RUN is cycles 2..len+1, DRAIN is cycles len+2..len+1+PU_LATENCY, and DONE is cycle len+2+PU_LATENCY.
- Start-to-done latency is len+PU_LATENCY+2 cycles. With len=3 and PU_LATENCY=1, `done` is high in cycle 6.
- `busy` rises the cycle after the accepted `start` and falls the cycle after DONE.
- The earliest back-to-back `start` is the cycle `busy` is 0 again, so there is one IDLE cycle between jobs.
- `err` is high exactly in the cycle after the rejected `start` edge.
- **Reset mid-job:** asynchronous return to the reset state; no `done` is produced and `result` reads 0. The next job runs normally because CLEAR always precedes RUN.
- **len=DEPTH:** idx reaches DEPTH−1 with no wrap; RUN lasts exactly DEPTH cycles.

## Test plan
- A={1,1,0}, B={2,1,1}, len=3:
  - `pu_en` is high for 3 cycles with pairs (1,2), (1,1), (0,1).
  - `done` fires in cycle 6 with `result`=3.
- Back-to-back jobs: after the previous job, a job with A[0]=5, B[0]=4, len=1 gives `result`=20, not 23, which checks that the PU is cleared.
- Overflow: A[0]=B[0]=0xFFFF, len=1 gives `result`=0x0001. A full len=16 run with all operands 0x0100 gives 0x0000.
- Rejected starts:
  - `start` with len=0, then with len=17: each produces a single `err` pulse with `busy`=0 and `pu_clr`/`pu_en` never asserted.
  - A `start` asserted during RUN is ignored.
- Write during `busy` to A[0] is dropped; a rerun of the same job returns the original result.
- Reset asserted (`reset`=0) in the 2nd RUN cycle:
  - All outputs go to 0 immediately and no `done` pulse follows.
  - After reload, a job with A={3,3}, B={3,3}, len=2 returns 18.
